dz_scan_engine: RTL and testbench

Parametrised bicolour dot-matrix scan engine for the egg-hatching game display. It stores a small image ROM, takes an image index or a random-image request from game control, and row-multiplexes the selected image onto an R×C red/green matrix at a programmable scan rate. Images swap only at frame boundaries, so a frame never mixes two images. A fail mode recolours the image green and blinks it. It replaces the fixed 8×8 transfer stage between game control and the matrix pins.

---
 rtl/dz_pkg.sv | 31 +++
 rtl/dz_image_rom.sv | 43 ++++
 rtl/dz_scan_engine.sv | 146 ++++++++++++++
 tb/tb_dz_scan_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dz_pkg.sv
// Shared constants, width helpers and display-mode type for the dot-matrix scan engine.
package dz_pkg;

  localparam int DZ_ROWS    = 8;
  localparam int DZ_COLS    = 8;
  localparam int DZ_NUM_IMG = 8;

  // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (feedback from bits 7,5,4,3)
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    DISP_RED   = 2'd0,
    DISP_GREEN = 2'd1,
    DISP_BLANK = 2'd2
  } disp_mode_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int img_w(input int num_img);
    return cnt_w(num_img);
  endfunction

  // img_sel bit that requests a random image sits just above the index field
  function automatic int rand_bit(input int num_img);
    return img_w(num_img);
  endfunction

endpackage

// File: rtl/dz_image_rom.sv
// Combinational image ROM: 8x8 egg-game bitmaps; slots outside the table read as zero.
module dz_image_rom
  import dz_pkg::*;
#(
  parameter int ROWS    = DZ_ROWS,
  parameter int COLS    = DZ_COLS,
  parameter int NUM_IMG = DZ_NUM_IMG,
  localparam int IW     = img_w(NUM_IMG),
  localparam int RW     = cnt_w(ROWS)
) (
  input  logic [IW-1:0]   img_idx,
  input  logic [RW-1:0]   row_idx,
  output logic [COLS-1:0] word
);

  logic [31:0] img_ext;
  logic [31:0] row_ext;
  logic [63:0] bitmap;
  logic [7:0]  line;

  // Bitmaps are written row 0 first (most significant byte); bit c is column c.
  always_comb begin
    img_ext = 32'(img_idx);
    row_ext = 32'(row_idx);
    bitmap  = '0;
    case (img_ext[2:0])
      3'd0: bitmap = 64'h183C_7E7E_FFFF_7E3C; // egg
      3'd1: bitmap = 64'h183C_5A7E_EFF7_7E3C; // cracked egg
      3'd2: bitmap = 64'h245A_3C7E_FFDB_7E3C; // hatching
      3'd3: bitmap = 64'h3C42_A581_A599_423C; // chick
      3'd4: bitmap = 64'h0066_FFFF_7E3C_1800; // bird
      3'd5: bitmap = 64'h1818_FF7E_3C66_C381; // star
      3'd6: bitmap = 64'h8142_2418_1824_4281; // cross
      3'd7: bitmap = 64'h183C_7EFF_1818_1818; // arrow
      default: bitmap = '0;
    endcase
    line = '0;
    if (img_ext < 32'd8 && row_ext < 32'd8)
      line = bitmap[8*(7 - int'(row_ext[2:0])) +: 8];
    word = COLS'(line);
  end

endmodule

// File: rtl/dz_scan_engine.sv
// Row-multiplexed bicolour matrix scan engine with frame-aligned image swap and fail-mode blink.
module dz_scan_engine
  import dz_pkg::*;
#(
  parameter int ROWS         = DZ_ROWS,
  parameter int COLS         = DZ_COLS,
  parameter int NUM_IMG      = DZ_NUM_IMG,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 16,
  localparam int IW          = img_w(NUM_IMG)
) (
  input  logic            clk,
  input  logic            dst_n,
  input  logic            load,
  input  logic [IW:0]     img_sel,
  input  logic            fail,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] colr,
  output logic [COLS-1:0] colg,
  output logic            frame_done
);

  localparam int PW       = cnt_w(SCAN_DIV);
  localparam int RW       = cnt_w(ROWS);
  localparam int BW       = cnt_w(BLINK_FRAMES);
  localparam int RAND_BIT = rand_bit(NUM_IMG);

  logic [PW-1:0]   presc;
  logic [RW-1:0]   row_idx;
  logic [IW-1:0]   cur_img;
  logic [IW-1:0]   pending;
  logic [IW-1:0]   load_val;
  logic            fail_q;
  logic [BW-1:0]   blink_cnt;
  logic            blank;
  logic [7:0]      lfsr;
  logic            tick;
  logic            boundary;
  logic [COLS-1:0] word;
  disp_mode_e      mode;

  assign tick     = (presc == PW'(SCAN_DIV - 1));
  assign boundary = tick && (row_idx == RW'(ROWS - 1));
  assign load_val = img_sel[RAND_BIT] ? lfsr[IW-1:0] : img_sel[IW-1:0];

  dz_image_rom #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .NUM_IMG (NUM_IMG)
  ) u_rom (
    .img_idx (cur_img),
    .row_idx (row_idx),
    .word    (word)
  );

  always_comb begin
    mode = DISP_RED;
    if (blank)       mode = DISP_BLANK;
    else if (fail_q) mode = DISP_GREEN;
  end

  always_ff @(posedge clk or negedge dst_n) begin
    if (!dst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge dst_n) begin
    if (!dst_n) begin
      presc   <= '0;
      row_idx <= '0;
    end else if (tick) begin
      presc   <= '0;
      row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
    end else begin
      presc   <= presc + PW'(1);
    end
  end

  // A load landing on the boundary cycle bypasses pending straight into cur_img.
  always_ff @(posedge clk or negedge dst_n) begin
    if (!dst_n) begin
      pending <= '0;
      cur_img <= '0;
    end else begin
      if (load)
        pending <= load_val;
      if (boundary)
        cur_img <= load ? load_val : pending;
    end
  end

  always_ff @(posedge clk or negedge dst_n) begin
    if (!dst_n) begin
      fail_q    <= 1'b0;
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (boundary) begin
      fail_q <= fail;
      if (!fail || !fail_q) begin
        blink_cnt <= '0;
        blank     <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blank     <= ~blank;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Slot outputs are latched with the pre-boundary image/colour state, so the
  // last row of a frame never picks up the next frame's settings.
  always_ff @(posedge clk or negedge dst_n) begin
    if (!dst_n) begin
      row        <= '1;
      colr       <= '0;
      colg       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        case (mode)
          DISP_BLANK: begin
            row  <= '1;
            colr <= '0;
            colg <= '0;
          end
          DISP_GREEN: begin
            row  <= ~(ROWS'(1) << row_idx);
            colr <= '0;
            colg <= word;
          end
          default: begin
            row  <= ~(ROWS'(1) << row_idx);
            colr <= word;
            colg <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dz_scan_engine.sv
// Directed self-checking bench for dz_scan_engine (8x8, 8 images, SCAN_DIV=4, BLINK_FRAMES=2).
module tb_dz_scan_engine;

  logic       clk = 1'b0;
  logic       dst_n = 1'b0;
  logic       load = 1'b0;
  logic       fail = 1'b0;
  logic [3:0] img_sel = 4'd0;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;
  logic       frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  localparam int M_RED   = 0;
  localparam int M_GREEN = 1;
  localparam int M_BLANK = 2;

  // Expected bitmaps, row 0 first per image; bit c = column c.
  localparam logic [7:0] ROM_T [0:63] = '{
    8'h18, 8'h3C, 8'h7E, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C,
    8'h18, 8'h3C, 8'h5A, 8'h7E, 8'hEF, 8'hF7, 8'h7E, 8'h3C,
    8'h24, 8'h5A, 8'h3C, 8'h7E, 8'hFF, 8'hDB, 8'h7E, 8'h3C,
    8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C,
    8'h00, 8'h66, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00,
    8'h18, 8'h18, 8'hFF, 8'h7E, 8'h3C, 8'h66, 8'hC3, 8'h81,
    8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81,
    8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h18, 8'h18, 8'h18, 8'h18
  };

  always #5 clk = ~clk;

  dz_scan_engine #(
    .ROWS         (8),
    .COLS         (8),
    .NUM_IMG      (8),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .dst_n      (dst_n),
    .load       (load),
    .img_sel    (img_sel),
    .fail       (fail),
    .row        (row),
    .colr       (colr),
    .colg       (colg),
    .frame_done (frame_done)
  );

  // Cycle k = sample point on the negedge after the k-th posedge since release.
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] er, input logic [7:0] ecr,
                     input logic [7:0] ecg);
    total++;
    assert ({row, colr, colg} === {er, ecr, ecg})
    else begin
      bad++;
      $error("FAIL %s @cyc%0d: row/colr/colg got %h/%h/%h want %h/%h/%h",
             tag, cyc, row, colr, colg, er, ecr, ecg);
    end
  endtask

  task automatic chk_fd(input string tag, input logic efd);
    total++;
    assert (frame_done === efd)
    else begin
      bad++;
      $error("FAIL %s @cyc%0d: frame_done got %b want %b", tag, cyc, frame_done, efd);
    end
  endtask

  // Row r of frame f is displayed from cycle 4 + 32f + 4r.
  task automatic slot(input string tag, input int f, input int r, input int img, input int m);
    logic [7:0] w;
    logic [7:0] er;
    go_to(4 + 32*f + 4*r);
    w  = ROM_T[img*8 + r];
    er = ~(8'd1 << r);
    if (m == M_BLANK)      chk(tag, 8'hFF, 8'h00, 8'h00);
    else if (m == M_GREEN) chk(tag, er, 8'h00, w);
    else                   chk(tag, er, w, 8'h00);
  endtask

  task automatic do_load(input int k, input logic [3:0] sel);
    go_to(k - 1);
    load    = 1'b1;
    img_sel = sel;
    go_to(k);
    load    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    dst_n = 1'b1;
    cyc   = 0;

    // Reset state and first frame of image 0
    chk("rst_out", 8'hFF, 8'h00, 8'h00);
    chk_fd("rst_fd", 1'b0);
    go_to(3);
    chk("pre_first_tick", 8'hFF, 8'h00, 8'h00);
    slot("f0_r0", 0, 0, 0, M_RED);
    go_to(7);
    chk("f0_r0_hold", 8'hFE, ROM_T[0], 8'h00);
    for (int r = 1; r < 7; r++) slot("f0_scan", 0, r, 0, M_RED);
    go_to(31);
    chk_fd("fd_before", 1'b0);
    slot("f0_r7", 0, 7, 0, M_RED);
    chk_fd("fd_pulse0", 1'b1);
    go_to(33);
    chk_fd("fd_after", 1'b0);

    // Tear-free swap; last load in a frame wins
    slot("f1_r0", 1, 0, 0, M_RED);
    do_load(45, 4'd2);
    do_load(53, 4'd3);
    slot("f1_r5_old", 1, 5, 0, M_RED);
    slot("f1_r6_old", 1, 6, 0, M_RED);
    slot("f1_r7_old", 1, 7, 0, M_RED);
    chk_fd("fd_pulse1", 1'b1);
    slot("f2_r0_new", 2, 0, 3, M_RED);
    slot("f2_r2_new", 2, 2, 3, M_RED);

    // Fail mode: current frame stays red, then 2 green, 2 blank, 2 green
    go_to(78);
    fail = 1'b1;
    slot("f2_r3_red", 2, 3, 3, M_RED);
    slot("f2_r7_red", 2, 7, 3, M_RED);
    slot("f3_r0_grn", 3, 0, 3, M_GREEN);
    slot("f3_r7_grn", 3, 7, 3, M_GREEN);
    slot("f4_r0_grn", 4, 0, 3, M_GREEN);
    slot("f4_r7_grn", 4, 7, 3, M_GREEN);
    slot("f5_r0_blk", 5, 0, 3, M_BLANK);
    slot("f5_r7_blk", 5, 7, 3, M_BLANK);
    slot("f6_r0_blk", 6, 0, 3, M_BLANK);
    slot("f6_r7_blk", 6, 7, 3, M_BLANK);
    slot("f7_r0_grn", 7, 0, 3, M_GREEN);
    slot("f8_r3_grn", 8, 3, 3, M_GREEN);
    go_to(274);
    fail = 1'b0;
    slot("f8_r7_grn", 8, 7, 3, M_GREEN);
    slot("f9_r0_red", 9, 0, 3, M_RED);

    // Load exactly on the boundary cycle is committed at that boundary
    slot("f9_r6_red", 9, 6, 3, M_RED);
    do_load(320, 4'd6);
    slot("f9_r7_old", 9, 7, 3, M_RED);
    slot("f10_r0_bypass", 10, 0, 6, M_RED);
    slot("f10_r3_bypass", 10, 3, 6, M_RED);

    // Asynchronous reset mid-frame
    go_to(337);
    dst_n = 1'b0;
    #1;
    chk("async_rst_out", 8'hFF, 8'h00, 8'h00);
    chk_fd("async_rst_fd", 1'b0);
    repeat (2) @(negedge clk);

    // Release with a random-select load in the first cycle (lfsr = 8'hA5 -> image 5)
    dst_n   = 1'b1;
    load    = 1'b1;
    img_sel = 4'b1000;
    cyc     = 0;
    chk("rel_out", 8'hFF, 8'h00, 8'h00);
    go_to(1);
    load = 1'b0;
    go_to(3);
    chk("rel_pre_tick", 8'hFF, 8'h00, 8'h00);
    slot("rel_f0_r0", 0, 0, 0, M_RED);
    slot("rel_f0_r7", 0, 7, 0, M_RED);
    slot("rand_f1_r0", 1, 0, 5, M_RED);
    slot("rand_f1_r5", 1, 5, 5, M_RED);
    go_to(64);
    chk_fd("rel_fd", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
